// File: rtl/led_pkg.sv
// Shared types and defaults for the WS2812B frame arbiter.
// State encoding, field widths, default gap length and a max helper.
package led_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARB,
    LAUNCH,
    WAIT_START,
    WAIT_DONE,
    GAP
  } state_t;

  localparam int COLOR_W        = 12;
  localparam int NUM_W          = 3;
  localparam int GAP_CYCLES_DEF = 28000;
  localparam int WD_CYCLES      = 1 << 20;

  function automatic int imax(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr,
// wrapping modulo NREQ; returns one-hot, index and valid.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [IW-1:0]   idx,
  output logic            valid
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!valid && req[(int'(ptr) + i) % NREQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(ptr) + i) % NREQ);
        onehot[(int'(ptr) + i) % NREQ] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_frame_arbiter.sv
// Round-robin sharing of one WS2812B frame sender among NREQ requesters.
// Define LED_ARB_WATCHDOG_EN to add a 2^20-cycle WAIT_DONE watchdog.
module led_frame_arbiter #(
  parameter int NREQ       = 2,
  parameter int COLOR_W    = led_pkg::COLOR_W,
  parameter int NUM_W      = led_pkg::NUM_W,
  parameter int GAP_CYCLES = led_pkg::GAP_CYCLES_DEF,
  parameter int START_TO   = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*COLOR_W-1:0] req_color,
  input  logic [NREQ*NUM_W-1:0]   req_num,
  input  logic                    ready2go,
  output logic                    go,
  output logic [COLOR_W-1:0]      sel_color,
  output logic [NUM_W-1:0]        sel_num,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    err
);

  import led_pkg::*;

  localparam int IW = $clog2(NREQ);
`ifdef LED_ARB_WATCHDOG_EN
  localparam int CMAX = imax(imax(GAP_CYCLES, START_TO), WD_CYCLES);
`else
  localparam int CMAX = imax(GAP_CYCLES, START_TO);
`endif
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] ST_LOAD  = CW'(START_TO - 1);
  localparam logic [CW-1:0] GAP_LOAD =
    CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  // A zero gap skips GAP entirely.
  localparam state_t GAP_NEXT = (GAP_CYCLES > 0) ? GAP : IDLE;
`ifdef LED_ARB_WATCHDOG_EN
  localparam logic [CW-1:0] WD_LOAD = CW'(WD_CYCLES - 1);
`endif

  state_t          state;
  logic [IW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] p_onehot;
  logic [IW-1:0]   p_idx;
  logic            p_valid;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (p_onehot),
    .idx    (p_idx),
    .valid  (p_valid)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      go        <= 1'b0;
      grant     <= '0;
      done      <= '0;
      err       <= 1'b0;
      sel_color <= '0;
      sel_num   <= '0;
      ptr       <= IW'(NREQ - 1);
      cnt       <= '0;
    end else begin
      go   <= 1'b0;
      done <= '0;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req && ready2go) state <= ARB;
        end
        ARB: begin
          if (p_valid) begin
            ptr       <= p_idx;
            sel_color <= req_color[p_idx*COLOR_W +: COLOR_W];
            sel_num   <= req_num[p_idx*NUM_W +: NUM_W];
            grant     <= p_onehot;
            go        <= 1'b1;
            state     <= LAUNCH;
          end else begin
            state <= IDLE;
          end
        end
        LAUNCH: begin
          cnt   <= ST_LOAD;
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (!ready2go) begin
`ifdef LED_ARB_WATCHDOG_EN
            cnt <= WD_LOAD;
`endif
            state <= WAIT_DONE;
          end else if (cnt == '0) begin
            err   <= 1'b1;
            done  <= grant;
            grant <= '0;
            cnt   <= GAP_LOAD;
            state <= GAP_NEXT;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT_DONE: begin
          if (ready2go) begin
            done  <= grant;
            grant <= '0;
            cnt   <= GAP_LOAD;
            state <= GAP_NEXT;
`ifdef LED_ARB_WATCHDOG_EN
          end else if (cnt == '0) begin
            err   <= 1'b1;
            done  <= grant;
            grant <= '0;
            cnt   <= GAP_LOAD;
            state <= GAP_NEXT;
          end else begin
            cnt <= cnt - 1'b1;
`endif
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
